// File: rtl/ram512_dma_pkg.sv
// ram512_dma_pkg
//   Shared definitions for the RAM512 fill/copy engine: default widths,
//   the command opcodes and the engine state encoding.
package ram512_dma_pkg;

  localparam int DEF_ADDR_WIDTH = 9;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_LEN_WIDTH  = 10;

  localparam logic OP_FILL = 1'b0;
  localparam logic OP_COPY = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FILL    = 3'd1,
    ST_COPY_RD = 3'd2,
    ST_COPY_WR = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  // True in the states where the engine, not the host, drives the RAM.
  function automatic logic is_engine_state(input state_t s);
    return (s == ST_FILL) || (s == ST_COPY_RD) || (s == ST_COPY_WR);
  endfunction

endpackage

// File: rtl/ram512_dma_mux.sv
// ram512_dma_mux
//   Combinational select of the RAM write port between the host and the
//   fill/copy engine.
// Ports:
//   engine_sel                       1 = engine owns the RAM, 0 = host
//   host_in/host_load/host_address   host-side RAM controls
//   eng_in/eng_load/eng_address      engine-side RAM controls
//   ram_in/ram_load/ram_address      controls driven into the RAM
module ram512_dma_mux
  import ram512_dma_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  engine_sel,
  input  logic [DATA_WIDTH-1:0] host_in,
  input  logic                  host_load,
  input  logic [ADDR_WIDTH-1:0] host_address,
  input  logic [DATA_WIDTH-1:0] eng_in,
  input  logic                  eng_load,
  input  logic [ADDR_WIDTH-1:0] eng_address,
  output logic [DATA_WIDTH-1:0] ram_in,
  output logic                  ram_load,
  output logic [ADDR_WIDTH-1:0] ram_address
);

  // While the engine owns the RAM the host controls are dropped entirely,
  // so a host write during a transfer is lost rather than queued.
  always_comb begin
    ram_in      = host_in;
    ram_load    = host_load;
    ram_address = host_address;
    if (engine_sel) begin
      ram_in      = eng_in;
      ram_load    = eng_load;
      ram_address = eng_address;
    end
  end

endmodule

// File: rtl/ram512_dma.sv
// ram512_dma
//   Fill/copy engine sitting in front of a RAM512. When idle the host port
//   passes straight through; on start it fills a range with a constant or
//   copies one range to another, ascending, wrapping modulo the RAM size.
// Ports:
//   clk, reset_n                     clock, asynchronous active-low reset
//   start, op                        command strobe (IDLE only), 0=fill 1=copy
//   src_addr, dst_addr, length       copy source, destination, word count
//   fill_value                       fill constant
//   busy, done                       engine owns RAM / one-cycle completion
//   host_in/host_load/host_address   host RAM port
//   host_out                         RAM read data back to the host
//   ram_in/ram_load/ram_address      drive the RAM
//   ram_out                          combinational RAM read data
module ram512_dma
  import ram512_dma_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  op,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  input  logic [DATA_WIDTH-1:0] fill_value,
  output logic                  busy,
  output logic                  done,
  input  logic [DATA_WIDTH-1:0] host_in,
  input  logic                  host_load,
  input  logic [ADDR_WIDTH-1:0] host_address,
  output logic [DATA_WIDTH-1:0] host_out,
  output logic [DATA_WIDTH-1:0] ram_in,
  output logic                  ram_load,
  output logic [ADDR_WIDTH-1:0] ram_address,
  input  logic [DATA_WIDTH-1:0] ram_out
);

  localparam int WORDS = 1 << ADDR_WIDTH;
  localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(WORDS);

  state_t                state;
  logic [LEN_WIDTH-1:0]  index;
  logic [DATA_WIDTH-1:0] hold;
  logic                  op_q;
  logic [ADDR_WIDTH-1:0] src_q;
  logic [ADDR_WIDTH-1:0] dst_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [DATA_WIDTH-1:0] fill_q;

  logic [LEN_WIDTH-1:0]  len_clamped;
  logic [LEN_WIDTH-1:0]  last_index;
  logic                  at_last;
  logic [ADDR_WIDTH-1:0] idx_lo;

  logic                  engine_sel;
  logic [DATA_WIDTH-1:0] eng_in;
  logic                  eng_load;
  logic [ADDR_WIDTH-1:0] eng_address;

  // Lengths beyond the RAM size would just revisit words, so they are cut
  // to one full pass.
  assign len_clamped = (length > MAX_LEN) ? MAX_LEN : length;
  assign last_index  = len_q - LEN_WIDTH'(1);
  assign at_last     = (index == last_index);
  assign idx_lo      = index[ADDR_WIDTH-1:0];

  assign host_out = ram_out;

  // Main sequencer. busy and done are registered alongside the state so
  // they change on the same edge as the state they describe. Operands are
  // captured on the start edge so later input changes cannot disturb a
  // transfer in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      index  <= '0;
      hold   <= '0;
      op_q   <= OP_FILL;
      src_q  <= '0;
      dst_q  <= '0;
      len_q  <= '0;
      fill_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          busy <= 1'b0;
          done <= 1'b0;
          if (start) begin
            op_q   <= op;
            src_q  <= src_addr;
            dst_q  <= dst_addr;
            len_q  <= len_clamped;
            fill_q <= fill_value;
            index  <= '0;
            if (len_clamped == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else if (op == OP_COPY) begin
              state <= ST_COPY_RD;
              busy  <= 1'b1;
            end else begin
              state <= ST_FILL;
              busy  <= 1'b1;
            end
          end
        end

        ST_FILL: begin
          if (at_last) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            index <= index + LEN_WIDTH'(1);
          end
        end

        ST_COPY_RD: begin
          hold  <= ram_out;
          state <= ST_COPY_WR;
        end

        ST_COPY_WR: begin
          if (at_last) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            index <= index + LEN_WIDTH'(1);
            state <= ST_COPY_RD;
          end
        end

        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Engine-side RAM controls are decoded straight from the state so that
  // an asynchronous reset drops the write enable in the same instant the
  // state returns to IDLE.
  always_comb begin
    engine_sel  = is_engine_state(state);
    eng_address = dst_q + idx_lo;
    eng_in      = fill_q;
    eng_load    = 1'b0;
    case (state)
      ST_FILL: begin
        eng_load = 1'b1;
      end
      ST_COPY_RD: begin
        eng_address = src_q + idx_lo;
      end
      ST_COPY_WR: begin
        eng_in   = hold;
        eng_load = 1'b1;
      end
      default: begin
        eng_load = 1'b0;
      end
    endcase
  end

  ram512_dma_mux #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mux (
    .engine_sel  (engine_sel),
    .host_in     (host_in),
    .host_load   (host_load),
    .host_address(host_address),
    .eng_in      (eng_in),
    .eng_load    (eng_load),
    .eng_address (eng_address),
    .ram_in      (ram_in),
    .ram_load    (ram_load),
    .ram_address (ram_address)
  );

  // op_q is captured for completeness; the sequencer already branched on
  // the live op at the start edge.
  logic unused_op;
  assign unused_op = op_q;

endmodule

// File: tb/tb_ram512_dma.sv
// tb_ram512_dma
//   Bench for ram512_dma driving a behavioural RAM512 (combinational read,
//   write on rising clock when load is high). Every expected RAM write and
//   every expected done pulse is queued when the stimulus is issued; a
//   monitor on the falling edge pops and compares them as they appear.
module tb_ram512_dma;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        op;
  logic [8:0]  src_addr;
  logic [8:0]  dst_addr;
  logic [9:0]  length;
  logic [15:0] fill_value;
  logic        busy;
  logic        done;
  logic [15:0] host_in;
  logic        host_load;
  logic [8:0]  host_address;
  logic [15:0] host_out;
  logic [15:0] ram_in;
  logic        ram_load;
  logic [8:0]  ram_address;
  logic [15:0] ram_out;

  logic [15:0] mem [0:511];

  typedef struct {
    logic [8:0]  addr;
    logic [15:0] data;
  } wr_t;

  wr_t exp_wr[$];
  int  exp_done[$];

  int vectors    = 0;
  int miscompares = 0;
  int busy_count = 0;

  ram512_dma dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .op          (op),
    .src_addr    (src_addr),
    .dst_addr    (dst_addr),
    .length      (length),
    .fill_value  (fill_value),
    .busy        (busy),
    .done        (done),
    .host_in     (host_in),
    .host_load   (host_load),
    .host_address(host_address),
    .host_out    (host_out),
    .ram_in      (ram_in),
    .ram_load    (ram_load),
    .ram_address (ram_address),
    .ram_out     (ram_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM512; each word starts at 0x4000 + address.
  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 16'h4000 + 16'(i);
  end
  always @(posedge clk) begin
    if (ram_load) mem[ram_address] <= ram_in;
  end
  assign ram_out = mem[ram_address];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: every RAM write must match the head of the write queue, and
  // every done pulse must match the queued busy-cycle count.
  always @(negedge clk) begin
    if (!reset_n) begin
      busy_count = 0;
    end else begin
      if (busy) busy_count++;
      if (ram_load) begin
        if (exp_wr.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                   ram_address, ram_in);
        end else begin
          wr_t w;
          w = exp_wr.pop_front();
          checkOutput("write_addr", 32'(ram_address), 32'(w.addr));
          checkOutput("write_data", 32'(ram_in), 32'(w.data));
        end
      end
      if (done) begin
        if (exp_done.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected_done: got done=1, expected 0");
        end else begin
          checkOutput("busy_cycles", 32'(busy_count), 32'(exp_done.pop_front()));
        end
        busy_count = 0;
      end
    end
  end

  task automatic push_write(input logic [8:0] a, input logic [15:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_wr.push_back(w);
  endtask

  // Issues a command; returns one time unit after the edge that sampled it.
  task automatic applyStimulus(input logic o, input logic [8:0] s,
                               input logic [8:0] d, input logic [9:0] l,
                               input logic [15:0] f);
    @(posedge clk); #1;
    op = o; src_addr = s; dst_addr = d; length = l; fill_value = f;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic host_write(input logic [8:0] a, input logic [15:0] d);
    push_write(a, d);
    @(posedge clk); #1;
    host_address = a; host_in = d; host_load = 1'b1;
    @(posedge clk); #1;
    host_load = 1'b0;
  endtask

  // Waits (bounded) for done, then confirms it lasts a single cycle.
  task automatic wait_done(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_done_seen"}, 32'(done), 32'(1));
    @(negedge clk);
    checkOutput({name, "_done_width"}, 32'(done), 32'(0));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; op = 1'b0; src_addr = '0; dst_addr = '0;
    length = '0; fill_value = '0; host_in = '0; host_load = 1'b0;
    host_address = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_busy", 32'(busy), 32'(0));
    checkOutput("reset_done", 32'(done), 32'(0));
    checkOutput("reset_load", 32'(ram_load), 32'(0));
    reset_n = 1'b1;

    host_address = 9'd5; #1;
    checkOutput("idle_addr_pass", 32'(ram_address), 32'(5));
    checkOutput("idle_host_out", 32'(host_out), 32'h4005);

    // Fill 10..13 with 0xBEEF; host write and a second start mid-transfer.
    for (int i = 10; i < 14; i++) push_write(9'(i), 16'hBEEF);
    exp_done.push_back(4);
    applyStimulus(1'b0, 9'd0, 9'd10, 10'd4, 16'hBEEF);
    checkOutput("fill_busy", 32'(busy), 32'(1));
    host_address = 9'd13; host_in = 16'h5555; host_load = 1'b1;
    start = 1'b1; op = 1'b1; length = 10'd7;
    @(posedge clk); #1;
    host_load = 1'b0; start = 1'b0;
    wait_done("fill");
    for (int i = 10; i < 14; i++) checkOutput("fill_word", 32'(mem[i]), 32'hBEEF);
    checkOutput("fill_after", 32'(mem[14]), 32'h400E);
    host_write(9'd13, 16'h0007);
    host_address = 9'd13; #1;
    checkOutput("host_write_after", 32'(host_out), 32'h0007);

    // Copy 100..102 -> 200..202.
    host_write(9'd100, 16'd1);
    host_write(9'd101, 16'd2);
    host_write(9'd102, 16'd3);
    push_write(9'd200, 16'd1);
    push_write(9'd201, 16'd2);
    push_write(9'd202, 16'd3);
    exp_done.push_back(6);
    applyStimulus(1'b1, 9'd100, 9'd200, 10'd3, 16'hFFFF);
    wait_done("copy");
    checkOutput("copy_w0", 32'(mem[200]), 32'd1);
    checkOutput("copy_w1", 32'(mem[201]), 32'd2);
    checkOutput("copy_w2", 32'(mem[202]), 32'd3);
    checkOutput("copy_after", 32'(mem[203]), 32'h40CB);

    // Fill wrapping from 511 to 0.
    push_write(9'd510, 16'h1234);
    push_write(9'd511, 16'h1234);
    push_write(9'd0, 16'h1234);
    push_write(9'd1, 16'h1234);
    exp_done.push_back(4);
    applyStimulus(1'b0, 9'd0, 9'd510, 10'd4, 16'h1234);
    wait_done("wrap");
    checkOutput("wrap_511", 32'(mem[511]), 32'h1234);
    checkOutput("wrap_0", 32'(mem[0]), 32'h1234);
    checkOutput("wrap_1", 32'(mem[1]), 32'h1234);
    checkOutput("wrap_after", 32'(mem[2]), 32'h4002);

    // Zero length: done right after the start edge, no write, never busy.
    exp_done.push_back(0);
    applyStimulus(1'b0, 9'd0, 9'd50, 10'd0, 16'hDEAD);
    checkOutput("len0_done", 32'(done), 32'(1));
    checkOutput("len0_busy", 32'(busy), 32'(0));
    checkOutput("len0_load", 32'(ram_load), 32'(0));
    wait_done("len0");
    checkOutput("len0_word", 32'(mem[50]), 32'h4032);

    // Reset after two words of a five-word copy 300.. -> 400..
    push_write(9'd400, 16'h412C);
    push_write(9'd401, 16'h412D);
    applyStimulus(1'b1, 9'd300, 9'd400, 10'd5, 16'h0000);
    repeat (4) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    checkOutput("abort_load", 32'(ram_load), 32'(0));
    checkOutput("abort_busy", 32'(busy), 32'(0));
    checkOutput("abort_done", 32'(done), 32'(0));
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("abort_w0", 32'(mem[400]), 32'h412C);
    checkOutput("abort_w1", 32'(mem[401]), 32'h412D);
    checkOutput("abort_w2", 32'(mem[402]), 32'h4192);

    checkOutput("pending_writes", 32'(exp_wr.size()), 32'(0));
    checkOutput("pending_dones", 32'(exp_done.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
